// File: rtl/me_frame_loader.sv
// rtl/me_frame_loader.sv - pixel loader, memory server and result capture for the 16x16 motion estimator
//
// Purpose: buffers one raster block (16x16 reference R, then 32x32 search window S),
// pulses the estimator's start, serves its three read ports and holds its result
// in a valid/ready register until downstream takes it.
//
// Ports:
//   clock, reset_n               clock (rising edge), asynchronous active-low reset
//   pix_data/pix_valid/pix_ready incoming pixel stream (accepted on valid & ready)
//   start                        one-cycle estimator start pulse
//   AddressR/AddressS1/AddressS2 estimator read addresses
//   R/S1/S2                      combinational read data for those addresses
//   completed/BestDist/motionX/motionY  estimator done flag and result
//   res_dist/res_mvx/res_mvy/res_valid/res_ready  captured result handshake
//   busy                         high whenever the loader is not idle
module me_frame_loader #(
  parameter  int DATA_W  = 8,
  parameter  int R_DEPTH = 256,
  parameter  int S_DEPTH = 1024,
  localparam int RA_W    = $clog2(R_DEPTH),
  localparam int SA_W    = $clog2(S_DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              start,
  input  logic [RA_W-1:0]   AddressR,
  input  logic [SA_W-1:0]   AddressS1,
  input  logic [SA_W-1:0]   AddressS2,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S1,
  output logic [DATA_W-1:0] S2,
  input  logic              completed,
  input  logic [7:0]        BestDist,
  input  logic [3:0]        motionX,
  input  logic [3:0]        motionY,
  output logic [7:0]        res_dist,
  output logic [3:0]        res_mvx,
  output logic [3:0]        res_mvy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_R,
    LOAD_S,
    START,
    SEARCH,
    REPORT
  } state_t;

  // The counter is wide enough for S; R uses only its low bits.
  localparam logic [SA_W-1:0] R_LAST = SA_W'(R_DEPTH - 1);
  localparam logic [SA_W-1:0] S_LAST = SA_W'(S_DEPTH - 1);

  state_t             state_q;
  logic [SA_W-1:0]    cnt_q;
  logic               pix_ready_q;
  logic               start_q;
  logic               busy_q;
  logic               completed_q;
  logic               res_valid_q;
  logic [7:0]         res_dist_q;
  logic [3:0]         res_mvx_q;
  logic [3:0]         res_mvy_q;

  logic [DATA_W-1:0]  r_mem [R_DEPTH];
  logic [DATA_W-1:0]  s_mem [S_DEPTH];

  logic               wr_en;
  logic               completed_rise;

  assign wr_en          = pix_valid & pix_ready_q;
  assign completed_rise = completed & ~completed_q;

  // Pixel storage is not reset. pix_ready_q is only high in IDLE/LOAD_R/LOAD_S,
  // and IDLE always has the counter at 0, so IDLE's pixel lands in R[0].
  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (state_q == LOAD_S) begin
        s_mem[cnt_q] <= pix_data;
      end else begin
        r_mem[cnt_q[RA_W-1:0]] <= pix_data;
      end
    end
  end

  // Zero-latency reads, legal in every state.
  assign R  = r_mem[AddressR];
  assign S1 = s_mem[AddressS1];
  assign S2 = s_mem[AddressS2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pix_ready_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_dist_q  <= '0;
      res_mvx_q   <= '0;
      res_mvy_q   <= '0;
    end else begin
      completed_q <= completed;
      case (state_q)
        IDLE: begin
          pix_ready_q <= 1'b1;
          if (wr_en) begin
            cnt_q   <= cnt_q + 1'b1;
            busy_q  <= 1'b1;
            state_q <= LOAD_R;
          end
        end
        LOAD_R: begin
          if (wr_en) begin
            if (cnt_q == R_LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_S;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_S: begin
          if (wr_en) begin
            if (cnt_q == S_LAST) begin
              cnt_q       <= '0;
              pix_ready_q <= 1'b0;
              start_q     <= 1'b1;
              state_q     <= START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= SEARCH;
        end
        SEARCH: begin
          // Only a fresh rising edge counts; a level left high from an
          // earlier block is never mistaken for this block's result.
          if (completed_rise) begin
            res_dist_q  <= BestDist;
            res_mvx_q   <= motionX;
            res_mvy_q   <= motionY;
            res_valid_q <= 1'b1;
            state_q     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pix_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          pix_ready_q <= 1'b0;
          start_q     <= 1'b0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready = pix_ready_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_dist  = res_dist_q;
  assign res_mvx   = res_mvx_q;
  assign res_mvy   = res_mvy_q;

endmodule

// File: tb/tb_me_frame_loader.sv
// tb/tb_me_frame_loader.sv - self-checking bench for me_frame_loader
module tb_me_frame_loader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic       start;
  logic [7:0] AddressR = '0;
  logic [9:0] AddressS1 = '0;
  logic [9:0] AddressS2 = '0;
  logic [7:0] R, S1, S2;
  logic       completed = 1'b0;
  logic [7:0] BestDist = '0;
  logic [3:0] motionX = '0;
  logic [3:0] motionY = '0;
  logic [7:0] res_dist;
  logic [3:0] res_mvx, res_mvy;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       busy;

  me_frame_loader dut (
    .clock(clock), .reset_n(reset_n),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .start(start),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .R(R), .S1(S1), .S2(S2),
    .completed(completed), .BestDist(BestDist), .motionX(motionX), .motionY(motionY),
    .res_dist(res_dist), .res_mvx(res_mvx), .res_mvy(res_mvy),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int n_acc, n_cyc;
  logic [7:0] acc_q[$];   // accepted pixels of the current block, in arrival order
  logic [7:0] exp_d;
  logic [3:0] exp_x, exp_y;

  always @(posedge clock) if (start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams pixels from negedge to negedge; a pixel counts as accepted when
  // valid is driven while ready is seen high. Stops after stop_at acceptances.
  task automatic load_block(input bit gaps, input bit pattern, input int stop_at,
                            output int acc, output int cyc);
    logic [7:0] d;
    logic       v;
    acc = 0;
    cyc = 0;
    acc_q.delete();
    while (acc < stop_at && cyc < 6000) begin
      @(negedge clock);
      cyc++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pattern) d = (acc < 256) ? 8'(acc) : 8'(acc - 256);
      else         d = 8'($urandom);
      pix_valid = v;
      pix_data  = d;
      if (v && pix_ready === 1'b1) begin
        acc_q.push_back(d);
        acc++;
      end
    end
  endtask

  // Expected: R[a] is the a-th accepted pixel, S[a] the (256+a)-th.
  task automatic sweep_mem(input string tag);
    int errs_before;
    errs_before = bad;
    for (int a = 0; a < 256; a++) begin
      AddressR = 8'(a);
      #1;
      check({tag, "_r"}, 32'(R), 32'(acc_q[a]));
    end
    for (int a = 0; a < 1024; a++) begin
      AddressS1 = 10'(a);
      AddressS2 = 10'(1023 - a);
      #1;
      check({tag, "_s1"}, 32'(S1), 32'(acc_q[256 + a]));
      check({tag, "_s2"}, 32'(S2), 32'(acc_q[256 + 1023 - a]));
    end
    if (bad != errs_before) $display("memory sweep %s saw %0d bad reads", tag, bad - errs_before);
    @(negedge clock);
  endtask

  task automatic check_start_pulse(input string tag);
    // Called on the negedge right after the last pixel was accepted.
    pix_valid = 1'b0;
    check({tag, "_start_hi"}, 32'(start), 32'd1);
    check({tag, "_rdy_start"}, 32'(pix_ready), 32'd0);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_no_early_start"}, 32'(start_cnt), 32'd0);
    @(negedge clock);
    check({tag, "_start_lo"}, 32'(start), 32'd0);
    check({tag, "_start_once"}, 32'(start_cnt), 32'd1);
    check({tag, "_rdy_search"}, 32'(pix_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_dist"}, 32'(res_dist), 32'd0);
    check({tag, "_res_mvx"}, 32'(res_mvx), 32'd0);
    check({tag, "_res_mvy"}, 32'(res_mvy), 32'd0);
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_rdy", 32'(pix_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // ---- block 1: counting pattern, no gaps ----
    start_cnt = 0;
    load_block(1'b0, 1'b1, 1280, n_acc, n_cyc);
    check("b1_acc", 32'(n_acc), 32'd1280);
    check("b1_cycles", 32'(n_cyc), 32'd1280);
    @(negedge clock);
    check_start_pulse("b1");

    AddressR = 8'h2A; AddressS1 = 10'h3FF; AddressS2 = 10'h100;
    #1;
    check("rd_R_2A", 32'(R), 32'h2A);
    check("rd_S1_3FF", 32'(S1), 32'hFF);
    check("rd_S2_100", 32'(S2), 32'h00);
    sweep_mem("b1");

    BestDist = 8'h17; motionX = 4'h5; motionY = 4'hC; completed = 1'b1;
    @(negedge clock);
    check("b1_res_valid", 32'(res_valid), 32'd1);
    check("b1_res_dist", 32'(res_dist), 32'h17);
    check("b1_res_mvx", 32'(res_mvx), 32'h5);
    check("b1_res_mvy", 32'(res_mvy), 32'hC);
    check("b1_report_rdy", 32'(pix_ready), 32'd0);
    BestDist = 8'h99; motionX = 4'h0; motionY = 4'h3;
    repeat (3) @(negedge clock);
    check("b1_hold_valid", 32'(res_valid), 32'd1);
    check("b1_hold_dist", 32'(res_dist), 32'h17);
    check("b1_hold_mvx", 32'(res_mvx), 32'h5);
    check("b1_hold_mvy", 32'(res_mvy), 32'hC);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check("b1_done_valid", 32'(res_valid), 32'd0);
    check("b1_done_rdy", 32'(pix_ready), 32'd1);
    check("b1_done_busy", 32'(busy), 32'd0);

    // ---- block 2: random data, 50% gaps, completed left high (stale) ----
    start_cnt = 0;
    load_block(1'b1, 1'b0, 1280, n_acc, n_cyc);
    check("b2_acc", 32'(n_acc), 32'd1280);
    @(negedge clock);
    check_start_pulse("b2");
    exp_d = 8'($urandom); exp_x = 4'($urandom); exp_y = 4'($urandom);
    BestDist = exp_d; motionX = exp_x; motionY = exp_y;
    repeat (4) @(negedge clock);
    check("b2_stale_ignored", 32'(res_valid), 32'd0);
    sweep_mem("b2");
    completed = 1'b0;
    @(negedge clock);
    check("b2_still_waiting", 32'(res_valid), 32'd0);
    completed = 1'b1;
    res_ready = 1'b1;
    @(negedge clock);
    check("b2_res_valid", 32'(res_valid), 32'd1);
    check("b2_res_dist", 32'(res_dist), 32'(exp_d));
    check("b2_res_mvx", 32'(res_mvx), 32'(exp_x));
    check("b2_res_mvy", 32'(res_mvy), 32'(exp_y));
    @(negedge clock);
    check("b2_fast_done", 32'(res_valid), 32'd0);
    check("b2_fast_rdy", 32'(pix_ready), 32'd1);
    res_ready = 1'b0;

    // ---- block 3: reset while loading S, then a fresh full load ----
    start_cnt = 0;
    load_block(1'b0, 1'b0, 600, n_acc, n_cyc);
    check("b3_acc", 32'(n_acc), 32'd600);
    @(negedge clock);
    pix_valid = 1'b0;
    check("b3_mid_busy", 32'(busy), 32'd1);
    check("b3_mid_rdy", 32'(pix_ready), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    completed = 1'b0;
    @(negedge clock);
    check("b4_idle_rdy", 32'(pix_ready), 32'd1);

    start_cnt = 0;
    load_block(1'b1, 1'b0, 1280, n_acc, n_cyc);
    check("b4_acc", 32'(n_acc), 32'd1280);
    @(negedge clock);
    check_start_pulse("b4");
    sweep_mem("b4");
    exp_d = 8'($urandom); exp_x = 4'($urandom); exp_y = 4'($urandom);
    BestDist = exp_d; motionX = exp_x; motionY = exp_y; completed = 1'b1;
    @(negedge clock);
    check("b4_res_valid", 32'(res_valid), 32'd1);
    check("b4_res_dist", 32'(res_dist), 32'(exp_d));
    check("b4_res_mvx", 32'(res_mvx), 32'(exp_x));
    check("b4_res_mvy", 32'(res_mvy), 32'(exp_y));
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check("b4_done_valid", 32'(res_valid), 32'd0);
    check("b4_done_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
